// File: rtl/wb_pkg.sv
// Writeback unit shared types and sizing.
// Scoreboard feature selected by WB_SCOREBOARD_EN.
package wb_pkg;

    localparam int XLEN          = 32;
    localparam int REG_AW        = 5;
    localparam int WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Register 0 never matches a source operand.
    function automatic logic rd_hit(
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] a,
        input logic [REG_AW-1:0] b
    );
        return (rd != '0) && ((rd == a) || (rd == b));
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order ALU result buffer with per-slot rd peek.
// Simultaneous push and pop keeps the count unchanged.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  wb_entry_t                    push_entry_i,
    input  logic                         pop_i,
    output wb_entry_t                    head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [REG_AW-1:0]            peek_rd_o [DEPTH],
    output logic [DEPTH-1:0]             peek_vld_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_pop) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= nxt(rptr_q);
            end
            if (do_push) begin
                vld_q[wptr_q] <= 1'b1;
                wptr_q        <= nxt(wptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Payload needs no reset; validity is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            peek_rd_o[i] = mem_q[i].rd;
        end
    end

    assign head_o     = mem_q[rptr_q];
    assign count_o    = cnt_q;
    assign peek_vld_o = vld_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: loads first, then buffered ALU results.
// Define WB_SCOREBOARD_EN to track pending loads for decode stalls.
module writeback_unit
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_issue_rd,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    output logic              stall,
    output logic              wr,
    output logic [REG_AW-1:0] Addr_Wr,
    output logic [XLEN-1:0]   Din
);

    localparam int CW = $clog2(WB_FIFO_DEPTH+1);

    logic [CW-1:0]            fifo_cnt;
    wb_entry_t                fifo_head;
    logic [REG_AW-1:0]        fifo_rd [WB_FIFO_DEPTH];
    logic [WB_FIFO_DEPTH-1:0] fifo_vld;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     alu_acc;
    wb_entry_t                alu_ent;
    wb_entry_t                out_ent;
    logic                     out_vld;
    logic                     fifo_hit;
    logic                     sb_hit;

    logic                     wr_q;
    logic                     wr_d;
    logic [REG_AW-1:0]        addr_q;
    logic [XLEN-1:0]          din_q;

    assign alu_ready  = fifo_cnt < CW'(WB_FIFO_DEPTH);
    assign alu_acc    = alu_valid && alu_ready;
    assign fifo_empty = (fifo_cnt == '0);
    assign alu_ent    = '{rd: alu_rd, data: alu_data};

    wb_fifo #(
        .DEPTH (WB_FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (alu_ent),
        .pop_i        (pop),
        .head_o       (fifo_head),
        .count_o      (fifo_cnt),
        .peek_rd_o    (fifo_rd),
        .peek_vld_o   (fifo_vld)
    );

    // Load returns cannot wait, so they always win the write port.
    always_comb begin
        out_vld = 1'b0;
        out_ent = alu_ent;
        push    = 1'b0;
        pop     = 1'b0;
        if (ld_valid) begin
            out_vld = 1'b1;
            out_ent = '{rd: ld_rd, data: ld_data};
            push    = alu_acc;
        end else if (!fifo_empty) begin
            out_vld = 1'b1;
            out_ent = fifo_head;
            pop     = 1'b1;
            push    = alu_acc;
        end else if (alu_acc) begin
            out_vld = 1'b1;
        end
    end

    assign wr_d = out_vld && (out_ent.rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            wr_q <= wr_d;
            if (wr_d) begin
                addr_q <= out_ent.rd;
                din_q  <= out_ent.data;
            end
        end
    end

    assign wr      = wr_q;
    assign Addr_Wr = addr_q;
    assign Din     = din_q;

    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && rd_hit(fifo_rd[i], chk_rs1, chk_rs2)) begin
                fifo_hit = 1'b1;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:1] busy_q;
    logic [31:1] busy_d;
    logic [31:0] busy_w;

    assign busy_w = {busy_q, 1'b0};
    assign sb_hit = busy_w[chk_rs1] | busy_w[chk_rs2];

    // A new issue to the same rd outranks the returning load's clear.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < 32; r++) begin
            if (ld_valid && (ld_rd == REG_AW'(r))) begin
                busy_d[r] = 1'b0;
            end
            if (ld_issue && (ld_issue_rd == REG_AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_ld_issue;

    assign unused_ld_issue = ^{ld_issue, ld_issue_rd};
    assign sb_hit          = 1'b0;
`endif

    assign stall = sb_hit | fifo_hit;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit.
// Scoreboard expectations follow WB_SCOREBOARD_EN.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        stall;
    logic        wr;
    logic [4:0]  Addr_Wr;
    logic [31:0] Din;

    int total = 0;
    int bad   = 0;

`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    writeback_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .stall       (stall),
        .wr          (wr),
        .Addr_Wr     (Addr_Wr),
        .Din         (Din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ld_issue    = 1'b0;
        ld_issue_rd = '0;
        ld_valid    = 1'b0;
        ld_rd       = '0;
        ld_data     = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] d);
        ld_valid = 1'b1;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    task automatic wcheck(
        input string       tag,
        input logic [4:0]  rd,
        input logic [31:0] d
    );
        chk({tag, "_wr"}, 32'(wr), 32'd1);
        chk({tag, "_addr"}, 32'(Addr_Wr), 32'(rd));
        chk({tag, "_din"}, Din, d);
    endtask

    initial begin
        rst     = 1'b1;
        chk_rs1 = '0;
        chk_rs2 = '0;
        idle();
        tick();
        tick();
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_addr", 32'(Addr_Wr), 32'd0);
        chk("rst_din", Din, 32'd0);
        chk("rst_rdy", 32'(alu_ready), 32'd1);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        tick();

        // single ALU bypass
        alu(5'd5, 32'hDEADBEEF);
        #1;
        chk("byp_rdy", 32'(alu_ready), 32'd1);
        tick();
        idle();
        wcheck("byp", 5'd5, 32'hDEADBEEF);
        tick();
        chk("byp_idle_wr", 32'(wr), 32'd0);
        chk("byp_hold_addr", 32'(Addr_Wr), 32'd5);

        // load collides with ALU
        ld(5'd7, 32'h11);
        alu(5'd3, 32'h22);
        tick();
        idle();
        chk_rs1 = 5'd3;
        #1;
        wcheck("col_ld", 5'd7, 32'h11);
        chk("col_fifo_stall", 32'(stall), 32'd1);
        tick();
        wcheck("col_alu", 5'd3, 32'h22);
        chk("col_nostall", 32'(stall), 32'd0);
        chk_rs1 = '0;

        // three loads back to back, FIFO fills
        ld(5'd10, 32'hA0);
        alu(5'd20, 32'hB0);
        tick();
        wcheck("bb_l0", 5'd10, 32'hA0);
        ld(5'd11, 32'hA1);
        alu(5'd21, 32'hB1);
        tick();
        wcheck("bb_l1", 5'd11, 32'hA1);
        ld(5'd12, 32'hA2);
        alu(5'd22, 32'hB2);
        #1;
        chk("bb_full_rdy", 32'(alu_ready), 32'd0);
        tick();
        wcheck("bb_l2", 5'd12, 32'hA2);
        ld_valid = 1'b0;
        #1;
        chk("bb_still_full", 32'(alu_ready), 32'd0);
        tick();
        wcheck("bb_a0", 5'd20, 32'hB0);
        #1;
        chk("bb_rdy_back", 32'(alu_ready), 32'd1);
        tick();
        idle();
        wcheck("bb_a1", 5'd21, 32'hB1);
        tick();
        wcheck("bb_a2", 5'd22, 32'hB2);
        tick();
        chk("bb_drained", 32'(wr), 32'd0);

        // rd 0 results are consumed silently
        ld(5'd1, 32'h55);
        alu(5'd0, 32'hFF);
        tick();
        idle();
        #1;
        chk("x0_stall", 32'(stall), 32'd0);
        wcheck("x0_ld", 5'd1, 32'h55);
        tick();
        chk("x0_fifo_wr", 32'(wr), 32'd0);
        alu(5'd0, 32'hFF);
        tick();
        idle();
        chk("x0_byp_wr", 32'(wr), 32'd0);
        tick();
        chk("x0_empty_rdy", 32'(alu_ready), 32'd1);

        // pending load tracking
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd9;
        tick();
        idle();
        chk_rs1 = 5'd9;
        #1;
        chk("sb_set", 32'(stall), 32'(SB));
        tick();
        chk("sb_hold", 32'(stall), 32'(SB));
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd9;
        ld(5'd9, 32'h99);
        tick();
        idle();
        #1;
        wcheck("sb_same_ld", 5'd9, 32'h99);
        chk("sb_set_wins", 32'(stall), 32'(SB));
        ld(5'd9, 32'h9A);
        #1;
        chk("sb_pre_clr", 32'(stall), 32'(SB));
        tick();
        idle();
        #1;
        wcheck("sb_clr_ld", 5'd9, 32'h9A);
        chk("sb_cleared", 32'(stall), 32'd0);
        chk_rs1     = '0;
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd17;
        tick();
        idle();
        chk_rs2 = 5'd17;
        #1;
        chk("sb_rs2", 32'(stall), 32'(SB));
        ld(5'd18, 32'h18);
        tick();
        idle();
        #1;
        wcheck("sb_nonbusy", 5'd18, 32'h18);
        chk("sb_nonbusy_keep", 32'(stall), 32'(SB));
        ld(5'd17, 32'h17);
        tick();
        idle();
        #1;
        chk("sb_rs2_clr", 32'(stall), 32'd0);
        chk_rs2 = '0;

        // reset mid-operation
        ld_issue    = 1'b1;
        ld_issue_rd = 5'd4;
        ld(5'd13, 32'hC3);
        alu(5'd14, 32'hC4);
        tick();
        ld_issue = 1'b0;
        ld(5'd15, 32'hC5);
        alu(5'd16, 32'hC6);
        tick();
        idle();
        chk_rs1 = 5'd4;
        chk_rs2 = 5'd14;
        #1;
        wcheck("mr_pre", 5'd15, 32'hC5);
        chk("mr_full", 32'(alu_ready), 32'd0);
        chk("mr_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_wr", 32'(wr), 32'd0);
        chk("mr_addr", 32'(Addr_Wr), 32'd0);
        chk("mr_din", Din, 32'd0);
        chk("mr_rdy", 32'(alu_ready), 32'd1);
        chk("mr_stall0", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_post_wr0", 32'(wr), 32'd0);
        tick();
        chk("mr_post_wr1", 32'(wr), 32'd0);
        chk("mr_post_stall", 32'(stall), 32'd0);
        chk_rs1 = '0;
        chk_rs2 = '0;
        alu(5'd6, 32'h1234);
        tick();
        idle();
        wcheck("mr_resume", 5'd6, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
 clk  in  1  clock; all state updates on posedge
 rst  in  1  asynchronous active-high reset
 alu_valid  in  1  ALU result offered
 alu_ready  out  1  ALU result accepted this cycle (alu_valid & alu_ready)
 alu_rd  in  5  ALU destination register
 alu_data  in  32  ALU result
 ld_issue  in  1  load dispatched to memory this cycle
 ld_issue_rd  in  5  destination of dispatched load
 ld_valid  in  1  load data returning; cannot be back-pressured
 ld_rd  in  5  destination of returning load
 ld_data  in  32  returning load data
 chk_rs1  in  5  decode-stage source register 1
 chk_rs2  in  5  decode-stage source register 2
 stall  out  1  decode must hold; a source is pending
 wr  out  1  register-file write enable (registered)
 Addr_Wr  out  5  register-file write address (registered)
 Din  out  32  register-file write data (registered)

Function
REQ-003 wr/Addr_Wr/Din SHALL be driven from posedge flops so they are stable before the register file's negedge write.
REQ-004 At each posedge the output register SHALL load, in priority order: (1) the load return if ld_valid; (2) the ALU FIFO head, popped; (3) the live ALU input, if alu_valid and FIFO empty (bypass, latency 1 cycle); (4) otherwise wr=0, with Addr_Wr/Din holding.
REQ-005 An accepted ALU result not consumed by REQ-004 SHALL be pushed into a 2-entry in-order FIFO.
REQ-006 alu_ready SHALL equal (FIFO count < 2), combinationally. Push and pop in the same cycle SHALL leave the count unchanged.
REQ-007 Any result with rd==0 SHALL be consumed normally but SHALL produce wr=0.
REQ-008 ALU results SHALL commit in acceptance order. Loads SHALL commit in return order. Every ld_valid cycle SHALL commit its data in the next output cycle.
REQ-009 A scoreboard busy[31:1] SHALL set busy[ld_issue_rd] on ld_issue (rd!=0), and SHALL clear busy[ld_rd] when ld_valid is committed.
REQ-010 If a set and a clear of the same rd occur in the same cycle, set SHALL win.
REQ-011 stall SHALL be combinational: busy[chk_rs1] | busy[chk_rs2] | (any valid FIFO entry with rd==chk_rs1 or rd==chk_rs2, rd!=0). Register 0 SHALL never cause a stall.
REQ-012 ld_valid for a non-busy rd SHALL still be written, and the scoreboard SHALL be left unchanged.

Reset
REQ-013 During rst the block SHALL hold: wr=0, Addr_Wr=0, Din=0, FIFO empty, busy all 0, stall=0, alu_ready=1.
REQ-014 Reset asserted mid-operation SHALL discard all buffered ALU results and pending-load tracking without issuing any write. The register file contents are not reset.

Configuration
REQ-015 With macro WB_SCOREBOARD_EN defined, REQ-009 to REQ-012 SHALL be implemented as written.
REQ-016 Without WB_SCOREBOARD_EN:
 - the busy array SHALL be absent;
 - ld_issue and ld_issue_rd SHALL be ignored;
 - stall SHALL reflect only FIFO matches;
 - load writeback SHALL be unchanged.

Structure
REQ-017 Package wb_pkg SHALL hold XLEN=32, REG_AW=5, WB_FIFO_DEPTH=2, and the struct wb_entry_t {rd, data}.
REQ-018 The FIFO SHALL be a separate sub-module wb_fifo (depth parameter, push/pop/count/entry-peek ports).

Verification
REQ-019 ALU alu_rd=5, data=0xDEADBEEF, FIFO empty, no load -> next cycle wr=1, Addr_Wr=5, Din=0xDEADBEEF.
REQ-020 ld_valid (rd=7, 0x11) coinciding with ALU (rd=3, 0x22) -> cycle+1 writes x7=0x11; cycle+2 writes x3=0x22.
REQ-021 Three back-to-back ld_valid cycles with ALU valid -> FIFO fills to 2, alu_ready=0; loads then drain in order and the ALU results follow.
REQ-022 ld_issue rd=9, then chk_rs1=9 -> stall=1 until the cycle after ld_valid rd=9 commits. Same-cycle ld_valid rd=9 with ld_issue rd=9 -> stall remains 1.
REQ-023 alu_rd=0 with data 0xFF -> wr stays 0. chk_rs1=0 -> stall=0.
REQ-024 rst pulsed with 2 FIFO entries and busy[4]=1 -> wr=0, alu_ready=1, stall=0 immediately; no stale write after release.
